immediate_gen: RTL and testbench

- Registered RV32I immediate generator in the single-cycle/pipelined core datapath, between instruction fetch and ALU/branch/address logic.
- Decodes the opcode of a 32-bit instruction and assembles the I/S/B/U/J immediate as a 32-bit value: sign-extended for I/S/B/J, upper-placed for U.
- Also reports the decoded format and whether the opcode carries no immediate.

---
 rtl/immediate_gen_if.sv | 22 ++
 rtl/immediate_gen.sv | 101 ++++++++++
 tb/tb_immediate_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/immediate_gen_if.sv
// Instruction-in / immediate-out bundle between fetch and the immediate generator.
interface immediate_gen_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 3;

    logic              en;
    logic [XLEN-1:0]   instruction;
    logic [XLEN-1:0]   imm;
    logic [TYPE_W-1:0] imm_type;
    logic              imm_valid;
    logic              no_imm;

    modport master (
        output en, instruction,
        input  imm, imm_type, imm_valid, no_imm
    );

    modport slave (
        input  en, instruction,
        output imm, imm_type, imm_valid, no_imm
    );
endinterface

// File: rtl/immediate_gen.sv
// Registered RV32I immediate generator: opcode decode to I/S/B/U/J immediate,
// format code and a no-immediate flag, one cycle after each en capture.
module immediate_gen (
    input logic            clk,
    input logic            rst_n,
    immediate_gen_if.slave bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned OPC_W  = 7;

    typedef enum logic [TYPE_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    logic [OPC_W-1:0] opcode_c;
    logic [XLEN-1:0]  imm_c;
    imm_fmt_e         fmt_c;
    logic             no_imm_c;

    logic [XLEN-1:0]  imm_q;
    imm_fmt_e         fmt_q;
    logic             valid_q;
    logic             no_imm_q;

    // Opcode-only format decode; every output has a default so no field leaks X.
    always_comb begin
        opcode_c = bus.instruction[OPC_W-1:0];
        imm_c    = '0;
        fmt_c    = FMT_NONE;
        no_imm_c = 1'b0;
        unique case (opcode_c)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                imm_c = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
                fmt_c = FMT_I;
            end
            OPC_STORE: begin
                imm_c = {{20{bus.instruction[31]}}, bus.instruction[31:25],
                         bus.instruction[11:7]};
                fmt_c = FMT_S;
            end
            OPC_BRANCH: begin
                imm_c = {{19{bus.instruction[31]}}, bus.instruction[31],
                         bus.instruction[7], bus.instruction[30:25],
                         bus.instruction[11:8], 1'b0};
                fmt_c = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c = {bus.instruction[31:12], 12'b0};
                fmt_c = FMT_U;
            end
            OPC_JAL: begin
                imm_c = {{11{bus.instruction[31]}}, bus.instruction[31],
                         bus.instruction[19:12], bus.instruction[20],
                         bus.instruction[30:21], 1'b0};
                fmt_c = FMT_J;
            end
            default: begin
                no_imm_c = 1'b1;
            end
        endcase
    end

    // Capture on en; results hold otherwise while imm_valid tracks en by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q    <= '0;
            fmt_q    <= FMT_NONE;
            valid_q  <= 1'b0;
            no_imm_q <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                imm_q    <= imm_c;
                fmt_q    <= fmt_c;
                no_imm_q <= no_imm_c;
            end
        end
    end

    assign bus.imm       = imm_q;
    assign bus.imm_type  = TYPE_W'(fmt_q);
    assign bus.imm_valid = valid_q;
    assign bus.no_imm    = no_imm_q;

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen: directed plan cases plus a random stream
// built by encoding chosen immediates into instructions.
module tb_immediate_gen;
    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    immediate_gen_if bus ();
    immediate_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_OPIMM = 7'b0010011,
                           OP_JALR = 7'b1100111, OP_SYS   = 7'b1110011,
                           OP_ST   = 7'b0100011, OP_BR    = 7'b1100011,
                           OP_LUI  = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL  = 7'b1101111, OP_OP    = 7'b0110011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic v);
        chk({tag, "_imm"},   bus.imm,                e.imm);
        chk({tag, "_type"},  32'(bus.imm_type),      32'(e.typ));
        chk({tag, "_valid"}, 32'(bus.imm_valid),     32'(v));
        chk({tag, "_noimm"}, 32'(bus.no_imm),        32'(e.no));
    endtask

    // Encoders: place an immediate value into the instruction fields of each format.
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [31:0] v, input logic [31:0] f);
        logic [31:0] w;
        w = f; w[31:20] = v[11:0]; w[6:0] = op;
        return w;
    endfunction
    function automatic logic [31:0] enc_s(input logic [6:0] op, input logic [31:0] v, input logic [31:0] f);
        logic [31:0] w;
        w = f; w[31:25] = v[11:5]; w[11:7] = v[4:0]; w[6:0] = op;
        return w;
    endfunction
    function automatic logic [31:0] enc_b(input logic [6:0] op, input logic [31:0] v, input logic [31:0] f);
        logic [31:0] w;
        w = f; w[31] = v[12]; w[7] = v[11]; w[30:25] = v[10:5]; w[11:8] = v[4:1]; w[6:0] = op;
        return w;
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [31:0] v, input logic [31:0] f);
        logic [31:0] w;
        w = f; w[31:12] = v[31:12]; w[6:0] = op;
        return w;
    endfunction
    function automatic logic [31:0] enc_j(input logic [6:0] op, input logic [31:0] v, input logic [31:0] f);
        logic [31:0] w;
        w = f; w[31] = v[20]; w[19:12] = v[19:12]; w[20] = v[11]; w[30:21] = v[10:1]; w[6:0] = op;
        return w;
    endfunction

    function automatic exp_t mk(input logic [31:0] v, input logic [2:0] t, input logic n);
        exp_t e;
        e.imm = v; e.typ = t; e.no = n;
        return e;
    endfunction

    // Random legal immediate of a random format, with the expected decoded value.
    task automatic gen_rand(output logic [31:0] ins, output exp_t e);
        logic [31:0]        r, f;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic [6:0]         i_ops [4];
        logic [6:0]         n_ops [4];
        int                 v;
        i_ops = '{OP_LOAD, OP_OPIMM, OP_JALR, OP_SYS};
        n_ops = '{OP_OP, 7'b0001111, 7'b0000000, 7'b1111111};
        r = $urandom;
        f = $urandom;
        case ($urandom_range(0, 5))
            0: begin ins = f; ins[6:0] = n_ops[$urandom_range(0, 3)]; e = mk(32'h0, 3'd0, 1'b1); end
            1: begin s12 = r[11:0]; v = int'(s12); ins = enc_i(i_ops[$urandom_range(0, 3)], v, f); e = mk(v, 3'd1, 1'b0); end
            2: begin s12 = r[11:0]; v = int'(s12); ins = enc_s(OP_ST, v, f); e = mk(v, 3'd2, 1'b0); end
            3: begin s13 = {r[11:0], 1'b0}; v = int'(s13); ins = enc_b(OP_BR, v, f); e = mk(v, 3'd3, 1'b0); end
            4: begin v = int'({r[19:0], 12'h000}); ins = enc_u(r[20] ? OP_LUI : OP_AUIPC, v, f); e = mk(v, 3'd4, 1'b0); end
            default: begin s21 = {r[19:0], 1'b0}; v = int'(s21); ins = enc_j(OP_JAL, v, f); e = mk(v, 3'd5, 1'b0); end
        endcase
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input exp_t e);
        bus.en = 1'b1;
        bus.instruction = ins;
        @(negedge clk);
        check_out(tag, e, 1'b1);
    endtask

    initial begin
        logic [31:0] ins;
        exp_t        e, cur;
        logic [31:0] q_ins [4];
        exp_t        q_exp [4];
        logic        en_r;

        // Reset with en high and a live instruction.
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.instruction = enc_i(OP_LOAD, 32'h7FF, $urandom);
        repeat (3) @(negedge clk);
        check_out("reset", mk(32'h0, 3'd0, 1'b0), 1'b0);
        rst_n = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        check_out("hold_after_reset", mk(32'h0, 3'd0, 1'b0), 1'b0);

        step("i_0f0", enc_i(OP_LOAD, 32'h0F0, $urandom), mk(32'h000000F0, 3'd1, 1'b0));
        step("i_428", enc_i(OP_LOAD, 32'h428, $urandom), mk(32'h00000428, 3'd1, 1'b0));
        step("i_f00", enc_i(OP_LOAD, 32'hF00, $urandom), mk(32'hFFFFFF00, 3'd1, 1'b0));
        step("i_f0f", enc_i(OP_LOAD, 32'hF0F, $urandom), mk(32'hFFFFFF0F, 3'd1, 1'b0));
        bus.en = 1'b0;
        bus.instruction = $urandom;
        @(negedge clk);
        check_out("hold_en0", mk(32'hFFFFFF0F, 3'd1, 1'b0), 1'b0);

        step("s_000",   enc_s(OP_ST, 32'h000, $urandom), mk(32'h00000000, 3'd2, 1'b0));
        step("s_8c0_a", enc_s(OP_ST, 32'h8C0, 32'h01FFF000), mk(32'hFFFFF8C0, 3'd2, 1'b0));
        step("s_8c0_b", enc_s(OP_ST, 32'h8C0, 32'h00000000), mk(32'hFFFFF8C0, 3'd2, 1'b0));
        step("s_604",   enc_s(OP_ST, 32'h604, $urandom), mk(32'h00000604, 3'd2, 1'b0));
        step("s_007",   enc_s(OP_ST, 32'h007, $urandom), mk(32'h00000007, 3'd2, 1'b0));

        step("b_0614", enc_b(OP_BR, 32'h0614, $urandom), mk(32'd1556, 3'd3, 1'b0));
        step("b_0652", enc_b(OP_BR, 32'h0652, $urandom), mk(32'd1618, 3'd3, 1'b0));
        step("b_0ff0", enc_b(OP_BR, 32'h0FF0, $urandom), mk(32'd4080, 3'd3, 1'b0));
        step("b_1000", enc_b(OP_BR, 32'h1000, $urandom), mk(32'hFFFFF000, 3'd3, 1'b0));

        step("lui",    enc_u(OP_LUI, 32'hABCDE000, $urandom), mk(32'hABCDE000, 3'd4, 1'b0));
        step("jal_m2", enc_j(OP_JAL, 32'hFFFFFFFE, $urandom), mk(32'hFFFFFFFE, 3'd5, 1'b0));
        step("jal_max", enc_j(OP_JAL, 32'h000FFFFE, $urandom), mk(32'h000FFFFE, 3'd5, 1'b0));

        ins = $urandom;
        ins[6:0] = OP_OP;
        step("op_noimm", ins, mk(32'h0, 3'd0, 1'b1));

        // Four back-to-back captures, then en drops.
        q_ins[0] = enc_i(OP_JALR, 32'h800, $urandom);  q_exp[0] = mk(32'hFFFFF800, 3'd1, 1'b0);
        q_ins[1] = enc_u(OP_AUIPC, 32'h12345000, $urandom); q_exp[1] = mk(32'h12345000, 3'd4, 1'b0);
        q_ins[2] = enc_s(OP_ST, 32'h7FF, $urandom);    q_exp[2] = mk(32'h000007FF, 3'd2, 1'b0);
        q_ins[3] = enc_b(OP_BR, 32'h1FFE, $urandom);   q_exp[3] = mk(32'hFFFFFFFE, 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("b2b_%0d", k), q_ins[k], q_exp[k]);
        end
        bus.en = 1'b0;
        @(negedge clk);
        check_out("b2b_drop", q_exp[3], 1'b0);

        // Asynchronous reset mid-cycle discards the pending capture.
        bus.en = 1'b1;
        bus.instruction = enc_u(OP_LUI, 32'hFFFFF000, $urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", mk(32'h0, 3'd0, 1'b0), 1'b0);
        @(negedge clk);
        check_out("reset_discard", mk(32'h0, 3'd0, 1'b0), 1'b0);
        rst_n = 1'b1;
        step("first_after_reset", enc_j(OP_JAL, 32'h00000800, $urandom), mk(32'h00000800, 3'd5, 1'b0));

        // Random stream with random en gaps.
        cur = mk(32'h00000800, 3'd5, 1'b0);
        for (int n = 0; n < 300; n++) begin
            gen_rand(ins, e);
            en_r = ($urandom_range(0, 3) != 0);
            bus.en = en_r;
            bus.instruction = ins;
            if (en_r) cur = e;
            @(negedge clk);
            check_out($sformatf("rand_%0d", n), cur, en_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
